// File: rtl/uart_msg_scheduler.sv
// Round-robin scheduler that drains complete messages from N_SRC source FIFOs into one 16-bit
// valid/ready stream (header + payload). Define MSG_CHECKSUM_EN to append an XOR trailer beat.
module uart_msg_scheduler #(
   parameter int N_SRC  = 4,
   parameter int SETTLE = 3,
   parameter int SW     = 3
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic [N_SRC-1:0]    SRC_EN,
   input  logic [N_SRC-1:0]    SRC_GFM,
   input  logic [8*N_SRC-1:0]  SRC_LEN,
   input  logic [N_SRC-1:0]    SRC_PARITY,
   input  logic [16*N_SRC-1:0] SRC_Q,
   output logic [N_SRC-1:0]    SRC_START,
   output logic [N_SRC-1:0]    SRC_RD_REQ,
   output logic [15:0]         OUT_DATA,
   output logic                OUT_VALID,
   input  logic                OUT_READY,
   output logic                OUT_SOP,
   output logic                OUT_EOP,
   output logic                BUSY,
   output logic [SW-1:0]       CUR_SRC
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_SETTLE,
      S_HDR,
      S_DATA,
`ifdef MSG_CHECKSUM_EN
      S_CSUM,
`endif
      S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [SW-1:0] rr_q, rr_d;
   logic [SW-1:0] cur_q, cur_d;
   logic [7:0]    cnt_q, cnt_d;
   logic [7:0]    len_q, len_d;
   logic          par_q, par_d;
   logic [7:0]    issued_q, issued_d;
   logic [7:0]    sent_q, sent_d;
   logic          infl_q;
   logic [1:0]    occ_q, occ_d;
   logic [15:0]   skid0_q, skid0_d;
   logic [15:0]   skid1_q, skid1_d;
`ifdef MSG_CHECKSUM_EN
   logic [15:0]   csum_q, csum_d;
`endif

   logic [N_SRC-1:0] req;
   logic             hi_found, lo_found;
   logic [SW-1:0]    hi_idx, lo_idx, gnt_idx;
   logic [7:0]       cur_len;
   logic             cur_par;
   logic [15:0]      src_word;
   logic [15:0]      hdr_word;
   logic             rd_go, pop, last_word;

   assign req       = SRC_GFM & SRC_EN;
   assign hdr_word  = {4'(cur_q), 3'b000, par_q, len_q};
   assign last_word = (sent_q + 8'd1 == len_q);
   assign BUSY      = (state_q != S_IDLE);
   assign CUR_SRC   = cur_q;

   // Descending scan leaves the lowest requester at or after the pointer in hi_idx, lowest overall in lo_idx.
   always_comb begin
      hi_found = 1'b0;
      lo_found = 1'b0;
      hi_idx   = '0;
      lo_idx   = '0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (req[i]) begin
            lo_found = 1'b1;
            lo_idx   = SW'(i);
            if (i >= int'(rr_q)) begin
               hi_found = 1'b1;
               hi_idx   = SW'(i);
            end
         end
      end
      gnt_idx = hi_found ? hi_idx : lo_idx;
   end

   always_comb begin
      cur_len   = '0;
      cur_par   = 1'b0;
      src_word  = '0;
      SRC_START  = '0;
      SRC_RD_REQ = '0;
      for (int i = 0; i < N_SRC; i++) begin
         if (cur_q == SW'(i)) begin
            cur_len       = SRC_LEN[8*i +: 8];
            cur_par       = SRC_PARITY[i];
            src_word      = SRC_Q[16*i +: 16];
            SRC_START[i]  = (state_q == S_START);
            SRC_RD_REQ[i] = rd_go;
         end
      end
   end

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d   = state_q;
      rr_d      = rr_q;
      cur_d     = cur_q;
      cnt_d     = cnt_q;
      len_d     = len_q;
      par_d     = par_q;
      issued_d  = issued_q;
      sent_d    = sent_q;
      occ_d     = occ_q;
      skid0_d   = skid0_q;
      skid1_d   = skid1_q;
`ifdef MSG_CHECKSUM_EN
      csum_d    = csum_q;
`endif
      OUT_VALID = 1'b0;
      OUT_DATA  = '0;
      OUT_SOP   = 1'b0;
      OUT_EOP   = 1'b0;
      rd_go     = 1'b0;
      pop       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (lo_found) begin
               cur_d   = gnt_idx;
               state_d = S_START;
            end
         end
         S_START: begin
            cnt_d   = '0;
            state_d = S_SETTLE;
         end
         S_SETTLE: begin
            if (cnt_q == 8'(SETTLE - 1)) begin
               len_d    = cur_len;
               par_d    = cur_par;
               issued_d = '0;
               sent_d   = '0;
               state_d  = S_HDR;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_HDR: begin
            OUT_VALID = 1'b1;
            OUT_DATA  = hdr_word;
            OUT_SOP   = 1'b1;
`ifdef MSG_CHECKSUM_EN
            csum_d = hdr_word;
            if (OUT_READY) state_d = (len_q != 8'd0) ? S_DATA : S_CSUM;
`else
            OUT_EOP = (len_q == 8'd0);
            if (OUT_READY) state_d = (len_q != 8'd0) ? S_DATA : S_DONE;
`endif
         end
         S_DATA: begin
            OUT_VALID = (occ_q != 2'd0);
            OUT_DATA  = skid0_q;
            pop       = OUT_VALID && OUT_READY;
            // The word popped this cycle frees its slot, which keeps one word per cycle flowing.
            rd_go     = (issued_q < len_q) &&
                        (({1'b0, occ_q} + {2'b00, infl_q} - {2'b00, pop}) < 3'd2);
`ifndef MSG_CHECKSUM_EN
            OUT_EOP = last_word;
`endif
            if (pop) begin
               sent_d = sent_q + 8'd1;
`ifdef MSG_CHECKSUM_EN
               csum_d = csum_q ^ skid0_q;
               if (last_word) state_d = S_CSUM;
`else
               if (last_word) state_d = S_DONE;
`endif
            end
         end
`ifdef MSG_CHECKSUM_EN
         S_CSUM: begin
            OUT_VALID = 1'b1;
            OUT_DATA  = csum_q;
            OUT_EOP   = 1'b1;
            if (OUT_READY) state_d = S_DONE;
         end
`endif
         S_DONE: begin
            rr_d    = (int'(cur_q) >= N_SRC - 1) ? '0 : cur_q + 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (rd_go) issued_d = issued_q + 8'd1;

      // A word lands from the source FIFO one cycle after its read request.
      case ({infl_q, pop})
         2'b10: begin
            if (occ_q == 2'd0) skid0_d = src_word;
            else               skid1_d = src_word;
            occ_d = occ_q + 2'd1;
         end
         2'b01: begin
            skid0_d = skid1_q;
            occ_d   = occ_q - 2'd1;
         end
         2'b11: begin
            if (occ_q == 2'd1) begin
               skid0_d = src_word;
            end else begin
               skid0_d = skid1_q;
               skid1_d = src_word;
            end
         end
         default: ;
      endcase
   end

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q  <= S_IDLE;
         rr_q     <= '0;
         cur_q    <= '0;
         cnt_q    <= '0;
         len_q    <= '0;
         par_q    <= 1'b0;
         issued_q <= '0;
         sent_q   <= '0;
         infl_q   <= 1'b0;
         occ_q    <= '0;
         skid0_q  <= '0;
         skid1_q  <= '0;
`ifdef MSG_CHECKSUM_EN
         csum_q   <= '0;
`endif
      end else begin
         state_q  <= state_d;
         rr_q     <= rr_d;
         cur_q    <= cur_d;
         cnt_q    <= cnt_d;
         len_q    <= len_d;
         par_q    <= par_d;
         issued_q <= issued_d;
         sent_q   <= sent_d;
         infl_q   <= rd_go;
         occ_q    <= occ_d;
         skid0_q  <= skid0_d;
         skid1_q  <= skid1_d;
`ifdef MSG_CHECKSUM_EN
         csum_q   <= csum_d;
`endif
      end
   end

endmodule

// File: tb/tb_uart_msg_scheduler.sv
// Directed bench for uart_msg_scheduler: behavioural source FIFOs, beat recorder and
// hand-computed expected messages, with MSG_CHECKSUM_EN-aware trailer expectations.
module tb_uart_msg_scheduler;
   localparam int N = 4;
`ifdef MSG_CHECKSUM_EN
   localparam bit CSUM = 1'b1;
`else
   localparam bit CSUM = 1'b0;
`endif

   logic            CLK = 1'b0;
   logic            RST = 1'b0;
   logic [N-1:0]    SRC_EN, SRC_GFM, SRC_PARITY;
   logic [8*N-1:0]  SRC_LEN;
   logic [16*N-1:0] SRC_Q;
   logic [N-1:0]    SRC_START, SRC_RD_REQ;
   logic [15:0]     OUT_DATA;
   logic            OUT_VALID, OUT_READY, OUT_SOP, OUT_EOP, BUSY;
   logic [2:0]      CUR_SRC;

   uart_msg_scheduler #(.N_SRC(N), .SETTLE(3), .SW(3)) dut (
      .CLK(CLK), .RST(RST),
      .SRC_EN(SRC_EN), .SRC_GFM(SRC_GFM), .SRC_LEN(SRC_LEN), .SRC_PARITY(SRC_PARITY), .SRC_Q(SRC_Q),
      .SRC_START(SRC_START), .SRC_RD_REQ(SRC_RD_REQ),
      .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
      .OUT_SOP(OUT_SOP), .OUT_EOP(OUT_EOP), .BUSY(BUSY), .CUR_SRC(CUR_SRC)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [15:0] d;
      logic        sop;
      logic        eop;
      int          cyc;
   } beat_t;

   beat_t        beats[$];
   int           start_log[$];
   int           rd_cnt[N];
   logic [15:0]  fifo[N][$];
   logic [N-1:0] drop_mask;
   bit           toggle;
   int           cyc, eop_cnt, viol, out_cnt, words_left;
   int           n_checks = 0;
   int           n_fail = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int slog(input int k);
      return (start_log.size() > k) ? start_log[k] : -1;
   endfunction

   function automatic int bcyc(input int k);
      return (beats.size() > k) ? beats[k].cyc : -1;
   endfunction

   // One clock: sample outputs mid-cycle, then model the source FIFOs and stimulus after the edge.
   task automatic tick();
      logic [N-1:0] rq, st;
      logic         xfer, pop;
      @(negedge CLK);
      cyc++;
      rq   = SRC_RD_REQ;
      st   = SRC_START;
      xfer = OUT_VALID && OUT_READY;
      pop  = xfer && !OUT_SOP && (words_left > 0);
      if (xfer) begin
         beats.push_back('{OUT_DATA, OUT_SOP, OUT_EOP, cyc});
         if (OUT_EOP) eop_cnt++;
         if (OUT_SOP) words_left = int'(OUT_DATA[7:0]);
         else if (pop) words_left--;
      end
      if (rq != '0 && (out_cnt - int'(pop)) >= 2) viol++;
      if ($countones(rq) > 1 || $countones(st) > 1) viol++;
      out_cnt += $countones(rq) - int'(pop);
      for (int i = 0; i < N; i++) begin
         if (rq[i]) rd_cnt[i]++;
         if (st[i]) start_log.push_back(i);
      end
      @(posedge CLK);
      #1;
      for (int i = 0; i < N; i++)
         if (rq[i]) SRC_Q[16*i +: 16] = (fifo[i].size() > 0) ? fifo[i].pop_front() : 16'hDEAD;
      SRC_GFM = SRC_GFM & ~(st & drop_mask);
      if (toggle) OUT_READY = ~OUT_READY;
   endtask

   task automatic clear();
      beats.delete();
      start_log.delete();
      for (int i = 0; i < N; i++) rd_cnt[i] = 0;
      eop_cnt = 0;
      viol    = 0;
      cyc     = 0;
   endtask

   task automatic do_reset();
      RST = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      RST        = 1'b1;
      out_cnt    = 0;
      words_left = 0;
   endtask

   task automatic load(input int s, input logic [7:0] len, input logic par, input logic [15:0] w[$]);
      fifo[s]           = w;
      SRC_LEN[8*s +: 8] = len;
      SRC_PARITY[s]     = par;
   endtask

   task automatic run_until(input string tag, input int n);
      int budget = 0;
      while (eop_cnt < n && budget < 300) begin
         tick();
         budget++;
      end
      check({tag, ":finish"}, 32'(eop_cnt >= n), 32'd1);
   endtask

   task automatic check_msg(input string tag, input int k, input logic [15:0] hdr, input logic [15:0] w[$]);
      int          n;
      logic [15:0] cs;
      n  = w.size();
      cs = hdr;
      if (beats.size() < k + n + 1 + int'(CSUM)) begin
         check({tag, ":beats"}, 32'(beats.size()), 32'(k + n + 1 + int'(CSUM)));
         return;
      end
      check({tag, ":hdr"}, {beats[k].sop, beats[k].eop, beats[k].d}, {1'b1, (n == 0) && !CSUM, hdr});
      for (int j = 0; j < n; j++) begin
         cs = cs ^ w[j];
         check($sformatf("%s:w%0d", tag, j), {beats[k+1+j].sop, beats[k+1+j].eop, beats[k+1+j].d},
               {1'b0, (j == n - 1) && !CSUM, w[j]});
      end
`ifdef MSG_CHECKSUM_EN
      check({tag, ":trl"}, {beats[k+1+n].sop, beats[k+1+n].eop, beats[k+1+n].d}, {1'b0, 1'b1, cs});
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] w1[$], w2a[$], w2b[$], w2c[$], w2d[$], w3[$], w5a[$], w5b[$], w6[$], e[$];
      int b;
      SRC_EN = '1; SRC_GFM = '0; SRC_PARITY = '0; SRC_LEN = '0; SRC_Q = '0;
      OUT_READY = 1'b1; toggle = 1'b0; drop_mask = '1;
      out_cnt = 0; words_left = 0;
      clear();

      // Reset values
      repeat (2) @(posedge CLK);
      #1;
      check("rst:start", SRC_START, '0);
      check("rst:rdreq", SRC_RD_REQ, '0);
      check("rst:flags", {OUT_VALID, OUT_SOP, OUT_EOP, BUSY}, 4'b0000);
      check("rst:data", OUT_DATA, 16'h0000);
      check("rst:cur", CUR_SRC, 3'd0);
      RST = 1'b1;

      // T1: single message on src1, len 3, READY held high
      clear();
      w1 = {16'h00A1, 16'h00A2, 16'h00A3};
      load(1, 8'd3, 1'b0, w1);
      SRC_GFM = 4'b0010;
      run_until("t1", 1);
      repeat (3) tick();
      check("t1:nbeats", beats.size(), 4 + int'(CSUM));
      check_msg("t1", 0, 16'h1003, w1);
      check("t1:rd1", rd_cnt[1], 3);
      check("t1:rd_other", rd_cnt[0] + rd_cnt[2] + rd_cnt[3], 0);
      check("t1:nstarts", start_log.size(), 1);
      check("t1:start_src", slog(0), 1);
      check("t1:thruput", bcyc(3) - bcyc(1), 2);
      check("t1:credit", viol, 0);

      // T2: src0 and src2 together from pointer 0, then src0 alone, then src1 disabled
      do_reset();
      clear();
      w2a = {16'h0B01};
      w2b = {16'h0B02};
      load(0, 8'd1, 1'b0, w2a);
      load(2, 8'd1, 1'b0, w2b);
      SRC_GFM = 4'b0101;
      run_until("t2a", 2);
      check("t2a:first", slog(0), 0);
      check("t2a:second", slog(1), 2);
      check_msg("t2a0", 0, 16'h0001, w2a);
      check_msg("t2a2", 2 + int'(CSUM), 16'h2001, w2b);
      clear();
      w2c = {16'h0B03};
      load(0, 8'd1, 1'b0, w2c);
      SRC_GFM = 4'b0001;
      run_until("t2b", 1);
      check("t2b:src0", slog(0), 0);
      check_msg("t2b", 0, 16'h0001, w2c);
      clear();
      SRC_EN = 4'b1101;
      w2d = {16'h0B04};
      load(1, 8'd1, 1'b0, w2d);
      load(2, 8'd1, 1'b1, w2d);
      SRC_GFM = 4'b0110;
      run_until("t2c", 1);
      SRC_GFM = '0;
      SRC_EN  = '1;
      fifo[1].delete();
      repeat (3) tick();
      check("t2c:skip_dis", slog(0), 2);
      check_msg("t2c", 0, 16'h2101, w2d);
      check("t2c:cur", CUR_SRC, 3'd2);
      check("t2c:rd1", rd_cnt[1], 0);

      // T3: src3, len 2, parity set, READY toggling every cycle
      clear();
      w3 = {16'h5555, 16'hAAAA};
      load(3, 8'd2, 1'b1, w3);
      SRC_GFM = 4'b1000;
      toggle  = 1'b1;
      run_until("t3", 1);
      toggle    = 1'b0;
      OUT_READY = 1'b1;
      repeat (3) tick();
      check("t3:nbeats", beats.size(), 3 + int'(CSUM));
      check_msg("t3", 0, 16'h3102, w3);
      check("t3:rd3", rd_cnt[3], 2);
      check("t3:credit", viol, 0);

      // T4: len 0 on src3 with GFM held high: header-only, re-granted next round
      clear();
      load(3, 8'd0, 1'b0, e);
      drop_mask = 4'b0111;
      SRC_GFM   = 4'b1000;
      run_until("t4", 2);
      SRC_GFM   = '0;
      drop_mask = '1;
      repeat (4) tick();
      check("t4:nstarts", start_log.size(), 2);
      check("t4:regrant", {slog(0), slog(1)}, {32'd3, 32'd3});
      check_msg("t4m0", 0, 16'h3000, e);
      check_msg("t4m1", 1 + int'(CSUM), 16'h3000, e);
      check("t4:rd3", rd_cnt[3], 0);

      // T5: move pointer to 2, then reset during DATA after 2 of 5 words
      clear();
      w5a = {16'h0C01};
      load(1, 8'd1, 1'b0, w5a);
      SRC_GFM = 4'b0010;
      run_until("t5a", 1);
      repeat (2) tick();
      clear();
      w5b = {16'h0D01, 16'h0D02, 16'h0D03, 16'h0D04, 16'h0D05};
      load(2, 8'd5, 1'b0, w5b);
      SRC_GFM = 4'b0100;
      b = 0;
      while (beats.size() < 3 && b < 100) begin
         tick();
         b++;
      end
      check("t5:reached", 32'(beats.size() >= 3), 32'd1);
      check("t5:words", {beats.size() > 2 ? beats[2].d : 16'h0}, 16'h0D02);
      RST = 1'b0;
      #1;
      check("t5:rst_out", {SRC_START, SRC_RD_REQ, OUT_VALID, OUT_SOP, OUT_EOP, BUSY, OUT_DATA, CUR_SRC},
            '0);
      repeat (2) @(posedge CLK);
      #1;
      RST        = 1'b1;
      out_cnt    = 0;
      words_left = 0;
      check("t5:idle", BUSY, 1'b0);
      clear();
      load(1, 8'd0, 1'b0, e);
      load(3, 8'd0, 1'b0, e);
      SRC_GFM = 4'b1010;
      run_until("t5c", 2);
      repeat (3) tick();
      check("t5:ptr0", slog(0), 1);

`ifdef MSG_CHECKSUM_EN
      // T6: checksum trailer on src0
      clear();
      w6 = {16'h00FF, 16'h0F0F};
      load(0, 8'd2, 1'b0, w6);
      SRC_GFM = 4'b0001;
      run_until("t6", 1);
      repeat (3) tick();
      check_msg("t6", 0, 16'h0002, w6);
      check("t6:trailer", {beats.size() > 3 ? beats[3].d : 16'h0}, 16'h0FF2);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
